sram22_port_ctrl: RTL and testbench
===================================

Name: sram22_port_ctrl

Overview:
- Initiator-side controller for the single-port sram22 macro family (clk, we, wmask, addr, din, dout; one-cycle read latency).
- Accepts valid/ready read/write requests from a client and drives the macro port.
- Captures read data on the cycle it is valid, into a small response FIFO with backpressure-safe credit control.
- The macro's dout is only valid for one cycle and is overwritten by the next access, so reads are never lost under rsp_ready backpressure.

Parameters:
- DATA_WIDTH, 32, macro word width
- ADDR_WIDTH, 9, macro address width
- WMASK_WIDTH, 4, byte-lane write mask width (DATA_WIDTH/8)
- RSP_DEPTH, 2, response FIFO entries (>=2 needed for full throughput)

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid & req_ready
- req_we  in  1  1=write, 0=read
- req_wmask  in  WMASK_WIDTH  byte-lane enables for writes; ignored for reads
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  read data valid
- rsp_ready  in  1  client accepts read data
- rsp_rdata  out  DATA_WIDTH  read data, in request order
- sram_we  out  1  to macro we
- sram_wmask  out  WMASK_WIDTH  to macro wmask
- sram_addr  out  ADDR_WIDTH  to macro addr
- sram_din  out  DATA_WIDTH  to macro din
- sram_dout  in  DATA_WIDTH  from macro dout

Behaviour:
- Reset (rst=1 at a posedge): FIFO emptied, rd_inflight<=0, so rsp_valid=0 the following cycle. Reset mid-operation discards any in-flight read and all queued responses. req_ready is 0 while rst is high.
- fire = req_valid & req_ready.
- Macro drive is combinational, so the macro samples on the same edge the request fires:
  - sram_addr = req_addr, sram_din = req_wdata
  - sram_we = fire & req_we
  - sram_wmask = (fire & req_we) ? req_wmask : 0
- Idle cycles leave sram_we=0. The resulting dummy macro read is harmless.
- rd_inflight (1 bit) <= fire & ~req_we each cycle.
- When rd_inflight=1, sram_dout is pushed into the FIFO at the next posedge. Pushes are never blocked; the credit rule below guarantees space.
- Read latency: request fires on edge k; macro output is valid in cycle k..k+1; it is pushed on edge k+1; rsp_valid=1 from edge k+1. Minimum request-to-rsp_valid latency is 2 cycles.
- pop = rsp_valid & rsp_ready. rsp_rdata = FIFO head. rsp_valid = FIFO non-empty. The head is held stable while rsp_valid & ~rsp_ready.
- Credit rule: req_ready = ~rst & ((count + rd_inflight - pop) < RSP_DEPTH).
  - The rule applies to writes too, so req_ready is independent of req_we.
  - It gives a combinational path rsp_ready -> req_ready; this is intentional.
  - With RSP_DEPTH=2 and rsp_ready=1, back-to-back reads sustain 1 request/cycle.
- Writes produce no response. A write following a read on the next cycle is legal: the read data was already valid in the prior cycle and is captured at the write's edge.
- Simultaneous push and pop: count unchanged, pointers both advance. Pointers wrap modulo RSP_DEPTH. Count width is clog2(RSP_DEPTH+1).
- Ordering: responses are returned strictly in request order. No IDs.
- Illegal input: behaviour is undefined for payload X while req_valid=1. The block does not check address range.

Decomposition:
- Package sram22_pkg holds:
  - DATA_WIDTH, ADDR_WIDTH and WMASK_WIDTH defaults
  - a req_t struct {we, wmask, addr, wdata}
- One sub-module, sram22_rsp_fifo (parameterised width/depth, sync reset, push/pop/count/head). The credit logic and macro drive stay in the top.

Test Plan:
- Write addr 0x010 data 0xDEADBEEF wmask 4'hF, then read 0x010 with rsp_ready=1 -> rsp_rdata=0xDEADBEEF, rsp_valid exactly 2 cycles after read fire.
- Write 0x020=0x11223344 (4'hF), then write 0x020=0xAABBCCDD with wmask 4'b0101, then read -> 0x11BB33DD.
- 8 back-to-back reads of 0x000..0x007 (preloaded with i*0x01010101), rsp_ready=1 -> req_ready stays 1, 8 responses on consecutive cycles in order.
- 4 reads with rsp_ready=0 -> req_ready drops after 2 accepted, rsp_rdata held stable. Raise rsp_ready -> remaining 2 reads issue, all 4 responses arrive in order with none lost.
- Read 0x030 immediately followed by write 0x030=0x0 -> response is the old value, not X or 0.
- Issue a read, assert rst on the next edge -> rsp_valid stays 0 afterward, req_ready=0 during rst, then a normal read works after rst deasserts.

Source files
------------

// File: rtl/sram22_pkg.sv
// Shared defaults and types for the sram22 initiator-side port controller.
// The byte-merge helper is the reference for how a masked write combines with an old word.
package sram22_pkg;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_ADDR_WIDTH  = 9;
    localparam int DEF_WMASK_WIDTH = DEF_DATA_WIDTH / 8;

    typedef struct packed {
        logic                       we;
        logic [DEF_WMASK_WIDTH-1:0] wmask;
        logic [DEF_ADDR_WIDTH-1:0]  addr;
        logic [DEF_DATA_WIDTH-1:0]  wdata;
    } req_t;

    function automatic logic [DEF_DATA_WIDTH-1:0] merge_wmask(
        input logic [DEF_DATA_WIDTH-1:0]  old_word,
        input logic [DEF_DATA_WIDTH-1:0]  new_word,
        input logic [DEF_WMASK_WIDTH-1:0] mask
    );
        logic [DEF_DATA_WIDTH-1:0] r;
        r = old_word;
        for (int b = 0; b < DEF_WMASK_WIDTH; b++)
            if (mask[b]) r[b*8 +: 8] = new_word[b*8 +: 8];
        return r;
    endfunction

endpackage

// File: rtl/sram22_port_ctrl_if.sv
// Client-side request/response handshake bundle for sram22_port_ctrl.
// The client is the master; the controller is the slave.
interface sram22_port_ctrl_if
    import sram22_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int WMASK_WIDTH = DEF_WMASK_WIDTH
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [WMASK_WIDTH-1:0] req_wmask;
    logic [ADDR_WIDTH-1:0]  req_addr;
    logic [DATA_WIDTH-1:0]  req_wdata;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [DATA_WIDTH-1:0]  rsp_rdata;

    modport master (
        output req_valid, req_we, req_wmask, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_wmask, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/sram22_rsp_fifo.sv
// Small circular response FIFO with synchronous reset; push is never blocked,
// the caller's credit accounting guarantees space.
module sram22_rsp_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PW-1:0]               wptr, rptr;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= nxt(wptr);
            if (pop)  rptr <= nxt(rptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: an entry is only visible once count covers it.
    always_ff @(posedge clk) begin
        if (!rst && push) mem[wptr] <= din;
    end

    assign dout  = mem[rptr];
    assign empty = (count == '0);

endmodule

// File: rtl/sram22_port_ctrl.sv
// Initiator-side controller for a single-port sram22 macro with one-cycle read latency.
// Read data is captured the cycle after issue; credits keep the response FIFO from overflowing.
module sram22_port_ctrl
    import sram22_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int WMASK_WIDTH = DEF_WMASK_WIDTH,
    parameter int RSP_DEPTH   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    sram22_port_ctrl_if.slave      bus,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
);
    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic          ready, fire, pop, rsp_vld;
    logic          rd_inflight;
    logic          fifo_empty;
    logic [CW-1:0] count;
    logic [CW:0]   occ;

    // Occupancy counts the read already in the macro and credits a same-cycle pop,
    // so a full FIFO still accepts a new request while it drains.
    assign occ   = {1'b0, count} + {{CW{1'b0}}, rd_inflight} - {{CW{1'b0}}, pop};
    assign ready = ~rst & (occ < (CW + 1)'(RSP_DEPTH));
    assign fire  = bus.req_valid & ready;
    assign pop   = rsp_vld & bus.rsp_ready;

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_vld;
    assign rsp_vld       = ~fifo_empty;

    assign sram_addr  = bus.req_addr;
    assign sram_din   = bus.req_wdata;
    assign sram_we    = fire & bus.req_we;
    assign sram_wmask = (fire & bus.req_we) ? bus.req_wmask : '0;

    always_ff @(posedge clk) begin
        if (rst) rd_inflight <= 1'b0;
        else     rd_inflight <= fire & ~bus.req_we;
    end

    sram22_rsp_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RSP_DEPTH),
        .CW    (CW)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_inflight),
        .din   (sram_dout),
        .pop   (pop),
        .dout  (bus.rsp_rdata),
        .count (count),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_sram22_port_ctrl.sv
// Directed bench for sram22_port_ctrl with a behavioural sram22 macro and a response scoreboard.
module tb_sram22_port_ctrl;
    import sram22_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic                       sram_we;
    logic [DEF_WMASK_WIDTH-1:0] sram_wmask;
    logic [DEF_ADDR_WIDTH-1:0]  sram_addr;
    logic [DEF_DATA_WIDTH-1:0]  sram_din;
    logic [DEF_DATA_WIDTH-1:0]  sram_dout;

    sram22_port_ctrl_if bus ();

    sram22_port_ctrl #(.RSP_DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .sram_we    (sram_we),
        .sram_wmask (sram_wmask),
        .sram_addr  (sram_addr),
        .sram_din   (sram_din),
        .sram_dout  (sram_dout)
    );

    always #5 clk = ~clk;

    // Macro model: one-cycle read latency, dout overwritten by every access.
    logic [DEF_DATA_WIDTH-1:0] mem [0:(1<<DEF_ADDR_WIDTH)-1];
    always @(posedge clk) begin
        if (sram_we) mem[sram_addr] <= merge_wmask(mem[sram_addr], sram_din, sram_wmask);
        sram_dout <= mem[sram_addr];
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nfire = 0;
    logic [31:0] exp_q[$];
    bit burst_mode = 0;
    int burst_pops = 0;
    int burst_gaps = 0;
    int last_pop = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.req_valid && bus.req_ready) nfire <= nfire + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: compares every accepted response against the queue head.
    always @(negedge clk) begin
        if (bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got 0x%08h expected no response", bus.rsp_rdata);
            end else begin
                chk("rsp_data", bus.rsp_rdata, exp_q.pop_front());
            end
            if (burst_mode) begin
                if (burst_pops > 0 && cyc != last_pop + 1) burst_gaps++;
                last_pop = cyc;
                burst_pops++;
            end
        end
    end

    task automatic send(input req_t r, input bit track, input logic [31:0] exp, output int waits);
        bus.req_valid = 1'b1;
        bus.req_we    = r.we;
        bus.req_wmask = r.wmask;
        bus.req_addr  = r.addr;
        bus.req_wdata = r.wdata;
        waits = 0;
        @(negedge clk);
        while (!bus.req_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!bus.req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got req_ready=0 expected 1 within 50 cycles (addr 0x%03h)", r.addr);
        end else if (!r.we && track) begin
            exp_q.push_back(exp);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wr(input logic [8:0] a, input logic [31:0] d, input logic [3:0] m);
        int w;
        send('{we: 1'b1, wmask: m, addr: a, wdata: d}, 1'b0, 32'h0, w);
    endtask

    task automatic rd(input logic [8:0] a, input logic [31:0] exp, output int w);
        send('{we: 1'b0, wmask: 4'h0, addr: a, wdata: 32'h0}, 1'b1, exp, w);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1);
    end

    initial begin
        int w, wsum, base;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_wmask = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", {31'b0, bus.req_ready}, 32'd0);
        chk("reset_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Full write then read-back with latency check.
        wr(9'h010, 32'hDEADBEEF, 4'hF);
        rd(9'h010, 32'hDEADBEEF, w);
        @(negedge clk);
        chk("lat_cycle1_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        @(negedge clk);
        chk("lat_cycle2_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);

        // Partial byte-lane write.
        wr(9'h020, 32'h11223344, 4'hF);
        wr(9'h020, 32'hAABBCCDD, 4'b0101);
        rd(9'h020, 32'h11BB33DD, w);

        // Back-to-back reads at full rate.
        for (int i = 0; i < 8; i++) wr(9'(i), 32'h01010101 * i, 4'hF);
        burst_mode = 1;
        wsum = 0;
        for (int i = 0; i < 8; i++) begin
            rd(9'(i), 32'h01010101 * i, w);
            wsum += w;
        end
        repeat (4) @(posedge clk);
        #1 burst_mode = 0;
        chk("burst_req_stalls", 32'(wsum), 32'd0);
        chk("burst_rsp_count", 32'(burst_pops), 32'd8);
        chk("burst_rsp_gaps", 32'(burst_gaps), 32'd0);

        // Backpressure: only two reads accepted, head held stable.
        bus.rsp_ready = 1'b0;
        base = nfire;
        fork
            begin
                for (int i = 4; i < 8; i++) rd(9'(i), 32'h01010101 * i, w);
            end
            begin
                repeat (6) @(negedge clk);
                chk("bp_accepted", 32'(nfire - base), 32'd2);
                chk("bp_req_ready", {31'b0, bus.req_ready}, 32'd0);
                chk("bp_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
                chk("bp_head_a", bus.rsp_rdata, 32'h04040404);
                repeat (3) @(negedge clk);
                chk("bp_head_b", bus.rsp_rdata, 32'h04040404);
                @(posedge clk); #1;
                bus.rsp_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("bp_total_accepted", 32'(nfire - base), 32'd4);

        // Read immediately followed by a write to the same word.
        wr(9'h030, 32'hCAFEF00D, 4'hF);
        rd(9'h030, 32'hCAFEF00D, w);
        wr(9'h030, 32'h00000000, 4'hF);
        rd(9'h030, 32'h00000000, w);
        repeat (3) @(posedge clk);
        #1;

        // Reset while a read is in flight discards it.
        send('{we: 1'b0, wmask: 4'h0, addr: 9'h010, wdata: 32'h0}, 1'b0, 32'h0, w);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        end
        rd(9'h010, 32'hDEADBEEF, w);

        w = 0;
        while (exp_q.size() != 0 && w < 20) begin
            @(posedge clk);
            w++;
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
